// File: rtl/lbp_pkg.sv
// Shared types and frame geometry for the LBP gray-image memory arbiter.
// Latency: none (types and constants only). Backpressure: n/a.
package lbp_pkg;

  localparam int AW      = 14;
  localparam int DW      = 8;
  localparam int NPIX    = 16384;
  localparam int MEM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_GRAY = 1'b1
  } owner_t;

endpackage

// File: rtl/lbp_rd_tag_pipe.sv
// Read-return tag pipe: carries a valid bit and owner bit alongside the SRAM read.
// Latency: LAT cycles. Backpressure: none, every issued read returns after exactly LAT cycles.
module lbp_rd_tag_pipe
  import lbp_pkg::*;
#(
  parameter int LAT = MEM_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic in_vld,
  input  logic in_owner,
  output logic out_vld,
  output logic out_owner
);

  logic [LAT-1:0] vld_sr;
  logic [LAT-1:0] own_sr;

  // Reset clears the valid chain so reads in flight at reset never return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_sr <= '0;
      own_sr <= '0;
    end else begin
      vld_sr[0] <= in_vld;
      own_sr[0] <= in_owner;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        own_sr[i] <= own_sr[i-1];
      end
    end
  end

  assign out_vld   = vld_sr[LAT-1];
  assign out_owner = own_sr[LAT-1];

endmodule

// File: rtl/lbp_gray_mem_arbiter.sv
// Gray SRAM owner: host frame load, then host/engine read arbitration (LBP_ARB_RR_EN = round-robin).
// Latency: grants combinational, read data MEM_LAT cycles after grant. Backpressure: ungranted side holds req.
module lbp_gray_mem_arbiter
  import lbp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvld,
  output logic [DW-1:0] host_rdata,
  input  logic          frame_start,
  output logic          frame_busy,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic          gray_gnt,
  output logic          gray_rvld,
  output logic [DW-1:0] gray_data,
  output logic          gray_ready,
  input  logic          finish,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] WR_LAST = AW'(NPIX - 1);

  state_t        state;
  logic [AW-1:0] wr_cnt;
  logic          host_rd;
  logic          gray_win;
  logic          tag_vld;
  logic          tag_owner;
  owner_t        rd_owner;

`ifdef LBP_ARB_RR_EN
  owner_t        rr_ptr;
  logic          conflict;
  assign conflict = host_rd & gray_req;
`endif

  assign host_rd = host_req & ~host_we;

  // Grants are held low while reset is asserted so every output reads 0.
  always_comb begin
    host_gnt = 1'b0;
    gray_gnt = 1'b0;
    gray_win = 1'b0;
    if (reset) begin
      case (state)
        IDLE, LOAD: host_gnt = host_req;
        READY, RUN: begin
`ifdef LBP_ARB_RR_EN
          gray_win = gray_req & (~host_rd | (rr_ptr == OWN_GRAY));
`else
          gray_win = gray_req;
`endif
          gray_gnt = gray_win;
          host_gnt = host_rd & ~gray_win;
        end
        default: ;
      endcase
    end
  end

  assign mem_cen   = host_gnt | gray_gnt;
  assign mem_wen   = host_gnt & host_we;
  assign mem_addr  = host_gnt ? host_addr : (gray_gnt ? gray_addr : '0);
  assign mem_wdata = mem_wen ? host_wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      frame_busy <= 1'b0;
      gray_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          state      <= LOAD;
          wr_cnt     <= '0;
          frame_busy <= 1'b1;
        end
        LOAD: if (host_gnt && host_we) begin
          if (wr_cnt == WR_LAST) begin
            state      <= READY;
            gray_ready <= 1'b1;
          end else begin
            wr_cnt <= wr_cnt + 1'b1;
          end
        end
        READY: if (gray_gnt) state <= RUN;
        RUN: if (finish) begin
          state      <= IDLE;
          frame_busy <= 1'b0;
          gray_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LBP_ARB_RR_EN
  // After a contested grant the pointer favours whoever just lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= OWN_HOST;
    end else if (conflict && mem_cen) begin
      rr_ptr <= gray_gnt ? OWN_HOST : OWN_GRAY;
    end
  end
`endif

  assign rd_owner = gray_gnt ? OWN_GRAY : OWN_HOST;

  lbp_rd_tag_pipe #(.LAT(MEM_LAT)) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_vld    (mem_cen & ~mem_wen),
    .in_owner  (rd_owner == OWN_GRAY),
    .out_vld   (tag_vld),
    .out_owner (tag_owner)
  );

  assign host_rvld  = tag_vld & ~tag_owner;
  assign gray_rvld  = tag_vld &  tag_owner;
  assign host_rdata = host_rvld ? mem_rdata : '0;
  assign gray_data  = gray_rvld ? mem_rdata : '0;

endmodule

// File: tb/tb_lbp_gray_mem_arbiter.sv
// Directed bench for lbp_gray_mem_arbiter with a behavioural 1-cycle SRAM.
module tb_lbp_gray_mem_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int NPIX = 16384;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvld;
  logic [DW-1:0] host_rdata;
  logic          frame_start, frame_busy;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          gray_gnt, gray_rvld;
  logic [DW-1:0] gray_data;
  logic          gray_ready, finish;
  logic          mem_cen, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] sram [NPIX];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else         mem_rdata      <= sram[mem_addr];
    end
  end

  lbp_gray_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvld   (host_rvld),
    .host_rdata  (host_rdata),
    .frame_start (frame_start),
    .frame_busy  (frame_busy),
    .gray_req    (gray_req),
    .gray_addr   (gray_addr),
    .gray_gnt    (gray_gnt),
    .gray_rvld   (gray_rvld),
    .gray_data   (gray_data),
    .gray_ready  (gray_ready),
    .finish      (finish),
    .mem_cen     (mem_cen),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_host, n_gray;
  logic last_gray;
  logic exp_first_host;

  initial begin
    reset = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    frame_start = 1'b0; gray_req = 1'b0; gray_addr = '0; finish = 1'b0; mem_rdata = '0;
    for (int i = 0; i < NPIX; i++) sram[i] = 8'hFF;
    tick(); tick();
    @(negedge clk);
    chk("rst_frame_busy", {31'd0, frame_busy}, 32'd0);
    chk("rst_gray_ready", {31'd0, gray_ready}, 32'd0);
    chk("rst_mem_cen",    {31'd0, mem_cen},    32'd0);
    chk("rst_rvld",       {30'd0, host_rvld, gray_rvld}, 32'd0);
    reset = 1'b1;
    tick();

    // Test 1: 100 writes into LOAD, then reset mid-frame.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t1_busy", {31'd0, frame_busy}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = AW'(i); host_wdata = DW'(i);
      gray_req = 1'b1; gray_addr = 14'h0001;
      if (i == 50) begin
        @(negedge clk);
        chk("t1_load_host_gnt", {31'd0, host_gnt}, 32'd1);
        chk("t1_load_gray_gnt", {31'd0, gray_gnt}, 32'd0);
      end
      tick();
    end
    #2 reset = 1'b0;
    #1;
    chk("t1_abort_busy", {31'd0, frame_busy}, 32'd0);
    chk("t1_abort_outs", {27'd0, host_gnt, gray_gnt, mem_cen, mem_wen, gray_ready}, 32'd0);
    host_req = 1'b0; host_we = 1'b0; gray_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Test 2: full frame load; wr_cnt must restart from 0.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = AW'(i); host_wdata = DW'(i);
      if (i == NPIX - 1) begin
        @(negedge clk);
        chk("t2_ready_before_last", {31'd0, gray_ready}, 32'd0);
        chk("t2_last_gnt",          {31'd0, host_gnt},   32'd1);
      end
      tick();
    end
    host_req = 1'b0; host_we = 1'b0;
    chk("t2_gray_ready", {31'd0, gray_ready}, 32'd1);
    chk("t2_sram_0x1234", {24'd0, sram[14'h1234]}, 32'h34);

    // Test 3: host write refused in READY, then first engine read.
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0081; host_wdata = 8'hEE;
    @(negedge clk);
    chk("t3_ready_wr_gnt", {31'd0, host_gnt}, 32'd0);
    host_req = 1'b0; host_we = 1'b0;
    tick();
    gray_req = 1'b1; gray_addr = 14'h0081;
    @(negedge clk);
    chk("t3_gray_gnt", {31'd0, gray_gnt}, 32'd1);
    chk("t3_mem_addr", {18'd0, mem_addr}, 32'h81);
    tick();
    gray_req = 1'b0;
    chk("t3_gray_rvld", {31'd0, gray_rvld}, 32'd1);
    chk("t3_gray_data", {24'd0, gray_data}, 32'h81);

    // Test 4: 8 cycles of contention in RUN.
`ifdef LBP_ARB_RR_EN
    exp_first_host = 1'b1;
`else
    exp_first_host = 1'b0;
`endif
    n_host = 0; n_gray = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0005;
    gray_req = 1'b1; gray_addr = 14'h0123;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) chk("t4_first_host", {31'd0, host_gnt}, {31'd0, exp_first_host});
      chk("t4_one_grant", {31'd0, host_gnt ^ gray_gnt}, 32'd1);
      last_gray = gray_gnt;
      if (host_gnt) n_host++;
      if (gray_gnt) n_gray++;
      tick();
      if (last_gray) chk("t4_gray_ret", {23'd0, gray_rvld, gray_data}, 32'h123);
      else           chk("t4_host_ret", {23'd0, host_rvld, host_rdata}, 32'h105);
    end
    host_req = 1'b0; gray_req = 1'b0;
`ifdef LBP_ARB_RR_EN
    chk("t4_n_host", n_host, 32'd4);
    chk("t4_n_gray", n_gray, 32'd4);
`else
    chk("t4_n_host", n_host, 32'd0);
    chk("t4_n_gray", n_gray, 32'd8);
`endif

    // Test 5: host write in RUN is refused; SRAM unchanged.
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0081; host_wdata = 8'hEE;
    @(negedge clk);
    chk("t5_wr_gnt", {31'd0, host_gnt}, 32'd0);
    chk("t5_mem_wen", {31'd0, mem_wen}, 32'd0);
    tick();
    host_we = 1'b0;
    @(negedge clk);
    chk("t5_rd_gnt", {31'd0, host_gnt}, 32'd1);
    tick();
    host_req = 1'b0;
    chk("t5_rd_data", {23'd0, host_rvld, host_rdata}, 32'h181);

    // Test 6: finish coincident with an engine grant.
    gray_req = 1'b1; gray_addr = 14'h0010; finish = 1'b1;
    @(negedge clk);
    chk("t6_gray_gnt", {31'd0, gray_gnt}, 32'd1);
    tick();
    gray_req = 1'b0; finish = 1'b0;
    chk("t6_gray_ret", {23'd0, gray_rvld, gray_data}, 32'h110);
    chk("t6_idle", {30'd0, frame_busy, gray_ready}, 32'd0);
    gray_req = 1'b1;
    @(negedge clk);
    chk("t6_idle_gray_gnt", {31'd0, gray_gnt}, 32'd0);
    gray_req = 1'b0;
    tick();

    // In-flight read dropped by reset.
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0022;
    @(negedge clk);
    chk("t7_idle_rd_gnt", {31'd0, host_gnt}, 32'd1);
    reset = 1'b0;
    tick();
    host_req = 1'b0;
    chk("t7_rvld_dropped", {31'd0, host_rvld}, 32'd0);
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
